// File: rtl/mem_map_pkg.sv
// Address map constants and region encoding for the data-memory responder.
package mem_map_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h8000_0000;

    // Byte offsets inside the 16-byte MMIO window
    localparam logic [3:0] GPIO_OFS    = 4'h0;
    localparam logic [3:0] CYCLE_OFS   = 4'h4;
    localparam logic [3:0] STATUS_OFS  = 4'h8;
    localparam logic [3:0] SCRATCH_OFS = 4'hC;

    localparam int STATUS_ERR_BIT = 0;

    typedef enum logic [1:0] {
        REG_RAM  = 2'd0,
        REG_MMIO = 2'd1,
        REG_NONE = 2'd2
    } region_t;

endpackage

// File: rtl/data_ram.sv
// Word-addressed RAM: combinational read, synchronous write, contents survive reset.
module data_ram #(
    parameter int size      = 32,
    parameter int mem_depth = 256,
    parameter int AW        = $clog2(mem_depth)
) (
    input  logic            clk_i,
    input  logic            we_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [size-1:0] wdata_i,
    output logic [size-1:0] rdata_o
);

    logic [size-1:0] mem_q [mem_depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory target: decodes core accesses into RAM or the MMIO window
// (GPIO, CYCLE, STATUS, SCRATCH) and answers loads in the same cycle.
module data_mem_responder
    import mem_map_pkg::*;
#(
    parameter int              size      = 32,
    parameter int              mem_depth = 256,
    parameter logic [size-1:0] MMIO_BASE = size'(MMIO_BASE_DEFAULT)
) (
    input  logic            CLK,
    input  logic            RSTa,
    input  logic [size-1:0] address,
    input  logic [size-1:0] write_data,
    input  logic            MemWrite,
    input  logic            MemRead,
    output logic [size-1:0] read_data,
    output logic [size-1:0] gpio_out,
    output logic            bus_err
);

    localparam int              AW  = $clog2(mem_depth);
    localparam logic [size-1:0] ONE = {{(size-1){1'b0}}, 1'b1};

    logic [size-1:0] gpio_q, gpio_d;
    logic [size-1:0] cycle_q, cycle_d;
    logic [size-1:0] scratch_q, scratch_d;
    logic            err_q, err_d;

    region_t         region;
    logic            aligned;
    logic            err_access;
    logic            ram_we;
    logic            mmio_we;
    logic [size-1:0] ram_rdata;

    always_comb begin
        region = REG_NONE;
        if (address[size-1:AW+2] == '0) begin
            region = REG_RAM;
        end else if (address[size-1:4] == MMIO_BASE[size-1:4]) begin
            region = REG_MMIO;
        end
    end

    assign aligned = (address[1:0] == 2'b00);
    // A simultaneous load+store still performs the store but is flagged.
    assign err_access = (MemRead | MemWrite) &
                        (~aligned | (region == REG_NONE) | (MemRead & MemWrite));
    assign ram_we  = MemWrite & aligned & (region == REG_RAM) & ~RSTa;
    assign mmio_we = MemWrite & aligned & (region == REG_MMIO);

    data_ram #(
        .size      (size),
        .mem_depth (mem_depth),
        .AW        (AW)
    ) u_data_ram (
        .clk_i   (CLK),
        .we_i    (ram_we),
        .addr_i  (address[AW+1:2]),
        .wdata_i (write_data),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        read_data = '0;
        if (MemRead && aligned) begin
            if (region == REG_RAM) begin
                read_data = ram_rdata;
            end else if (region == REG_MMIO) begin
                case (address[3:0])
                    GPIO_OFS:    read_data = gpio_q;
                    CYCLE_OFS:   read_data = cycle_q;
                    STATUS_OFS:  read_data[STATUS_ERR_BIT] = err_q;
                    SCRATCH_OFS: read_data = scratch_q;
                    default:     read_data = '0;
                endcase
            end
        end
    end

    always_comb begin
        gpio_d    = gpio_q;
        cycle_d   = cycle_q + ONE;
        scratch_d = scratch_q;
        err_d     = err_q;
        if (mmio_we) begin
            case (address[3:0])
                GPIO_OFS:    gpio_d = write_data;
                CYCLE_OFS:   cycle_d = write_data;
                STATUS_OFS:  if (write_data[STATUS_ERR_BIT]) err_d = 1'b0;
                SCRATCH_OFS: scratch_d = write_data;
                default:     ;
            endcase
        end
        // Setting the error has priority over a same-edge W1C.
        if (err_access) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RSTa) begin
            gpio_q    <= '0;
            cycle_q   <= '0;
            scratch_q <= '0;
            err_q     <= 1'b0;
        end else begin
            gpio_q    <= gpio_d;
            cycle_q   <= cycle_d;
            scratch_q <= scratch_d;
            err_q     <= err_d;
        end
    end

    assign gpio_out = gpio_q;
    assign bus_err  = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: vector table, random RAM
// round-trips and hand-written counter / reset sequences.
module tb_data_mem_responder;

    localparam logic [31:0] GPIO_A    = 32'h8000_0000;
    localparam logic [31:0] CYCLE_A   = 32'h8000_0004;
    localparam logic [31:0] STATUS_A  = 32'h8000_0008;
    localparam logic [31:0] SCRATCH_A = 32'h8000_000C;

    typedef struct {
        logic        rst;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        we;
        logic        re;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        chk_gpio;
        logic [31:0] exp_gpio;
        logic        chk_err;
        logic        exp_err;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RSTa = 1'b1;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic [31:0] read_data;
    logic [31:0] gpio_out;
    logic        bus_err;

    int          n_cmp = 0;
    int          n_err = 0;
    int          tag = 0;
    logic [31:0] exp_q[$];
    vec_t        tbl[$];

    data_mem_responder dut (
        .CLK        (CLK),
        .RSTa       (RSTa),
        .address    (address),
        .write_data (write_data),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .read_data  (read_data),
        .gpio_out   (gpio_out),
        .bus_err    (bus_err)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, summary not yet printed");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic rst, input logic [31:0] addr, input logic [31:0] wd,
                                input logic we, input logic re,
                                input logic crd, input logic [31:0] erd,
                                input logic cg, input logic [31:0] eg,
                                input logic ce, input logic ee);
        vec_t v;
        v.rst = rst; v.addr = addr; v.wd = wd; v.we = we; v.re = re;
        v.chk_rd = crd; v.exp_rd = erd;
        v.chk_gpio = cg; v.exp_gpio = eg;
        v.chk_err = ce; v.exp_err = ee;
        return v;
    endfunction

    task automatic check(input string nm, input int t, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %h expected %h", nm, t, act, exp);
        end
    endtask

    // driver: inputs change on the falling edge, outputs sampled 1 ns later
    task automatic apply(input vec_t v);
        logic [31:0] e;
        @(negedge CLK);
        RSTa       = v.rst;
        address    = v.addr;
        write_data = v.wd;
        MemWrite   = v.we;
        MemRead    = v.re;
        if (v.chk_rd) exp_q.push_back(v.exp_rd);
        #1;
        if (v.chk_rd) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL read_data step %0d: got %h expected <queue empty>", tag, read_data);
            end else begin
                e = exp_q.pop_front();
                check("read_data", tag, read_data, e);
            end
        end
        if (v.chk_gpio) check("gpio_out", tag, gpio_out, v.exp_gpio);
        if (v.chk_err)  check("bus_err", tag, {31'b0, bus_err}, {31'b0, v.exp_err});
        tag++;
    endtask

    initial begin
        logic [7:0]  idx;
        logic [31:0] d;

        // rst addr wd we re | chk_rd exp_rd | chk_gpio exp_gpio | chk_err exp_err
        tbl.push_back(mk(1, 32'h0,      32'h0,          0, 0, 0, 32'h0,          0, 32'h0,  0, 0));
        tbl.push_back(mk(0, GPIO_A,     32'h0,          0, 0, 1, 32'h0,          1, 32'h0,  1, 0));
        tbl.push_back(mk(0, 32'h10,     32'h1111_1111,  1, 0, 1, 32'h0,          0, 32'h0,  1, 0));
        tbl.push_back(mk(0, 32'h10,     32'hDEAD_BEEF,  1, 1, 1, 32'h1111_1111,  0, 32'h0,  1, 0));
        tbl.push_back(mk(0, 32'h10,     32'h0,          0, 1, 1, 32'hDEAD_BEEF,  0, 32'h0,  1, 1));
        tbl.push_back(mk(0, STATUS_A,   32'h1,          1, 0, 1, 32'h0,          0, 32'h0,  1, 1));
        tbl.push_back(mk(0, STATUS_A,   32'h0,          0, 1, 1, 32'h0,          0, 32'h0,  1, 0));
        tbl.push_back(mk(0, GPIO_A,     32'hA5,         1, 0, 0, 32'h0,          1, 32'h0,  0, 0));
        tbl.push_back(mk(0, GPIO_A,     32'h0,          0, 1, 1, 32'hA5,         1, 32'hA5, 0, 0));
        tbl.push_back(mk(0, SCRATCH_A,  32'h1234_5678,  1, 0, 0, 32'h0,          0, 32'h0,  0, 0));
        tbl.push_back(mk(0, SCRATCH_A,  32'h0,          0, 1, 1, 32'h1234_5678,  0, 32'h0,  0, 0));
        tbl.push_back(mk(0, 32'h13,     32'hCAFE_F00D,  1, 0, 0, 32'h0,          0, 32'h0,  1, 0));
        tbl.push_back(mk(0, 32'h10,     32'h0,          0, 1, 1, 32'hDEAD_BEEF,  0, 32'h0,  1, 1));
        tbl.push_back(mk(0, 32'h4000_0000, 32'h0,       0, 1, 1, 32'h0,          0, 32'h0,  1, 1));
        tbl.push_back(mk(0, STATUS_A,   32'h0,          0, 1, 1, 32'h1,          0, 32'h0,  1, 1));
        tbl.push_back(mk(0, STATUS_A,   32'h1,          1, 1, 1, 32'h1,          0, 32'h0,  1, 1));
        tbl.push_back(mk(0, STATUS_A,   32'h0,          0, 1, 1, 32'h1,          0, 32'h0,  1, 1));
        tbl.push_back(mk(0, STATUS_A,   32'h1,          1, 0, 0, 32'h0,          0, 32'h0,  1, 1));
        tbl.push_back(mk(0, STATUS_A,   32'h0,          0, 1, 1, 32'h0,          0, 32'h0,  1, 0));
        tbl.push_back(mk(0, 32'h4000_0000, 32'h0,       0, 1, 1, 32'h0,          0, 32'h0,  1, 0));
        tbl.push_back(mk(0, 32'h0,      32'h0,          0, 0, 1, 32'h0,          0, 32'h0,  1, 1));
        tbl.push_back(mk(0, 32'h12,     32'h0,          0, 1, 1, 32'h0,          0, 32'h0,  1, 1));
        tbl.push_back(mk(0, STATUS_A,   32'hFFFF_FFFE,  1, 0, 0, 32'h0,          0, 32'h0,  1, 1));
        tbl.push_back(mk(0, STATUS_A,   32'h0,          0, 1, 1, 32'h1,          0, 32'h0,  1, 1));
        tbl.push_back(mk(0, STATUS_A,   32'h1,          1, 0, 0, 32'h0,          0, 32'h0,  1, 1));
        tbl.push_back(mk(0, 32'h3FC,    32'hA0A0_A0A0,  1, 0, 0, 32'h0,          0, 32'h0,  1, 0));
        tbl.push_back(mk(0, 32'h3FC,    32'h0,          0, 1, 1, 32'hA0A0_A0A0,  0, 32'h0,  1, 0));
        tbl.push_back(mk(0, 32'h400,    32'h0,          0, 1, 1, 32'h0,          0, 32'h0,  1, 0));
        tbl.push_back(mk(0, 32'h0,      32'h0,          0, 0, 0, 32'h0,          0, 32'h0,  1, 1));
        tbl.push_back(mk(0, STATUS_A,   32'h1,          1, 0, 0, 32'h0,          0, 32'h0,  1, 1));
        tbl.push_back(mk(0, 32'h8000_0010, 32'h0,       0, 1, 1, 32'h0,          0, 32'h0,  1, 0));
        tbl.push_back(mk(0, 32'h0,      32'h0,          0, 0, 0, 32'h0,          0, 32'h0,  1, 1));
        tbl.push_back(mk(0, STATUS_A,   32'h1,          1, 0, 0, 32'h0,          0, 32'h0,  1, 1));
        tbl.push_back(mk(0, 32'h8000_0001, 32'h55,      1, 0, 0, 32'h0,          1, 32'hA5, 1, 0));
        tbl.push_back(mk(0, GPIO_A,     32'h0,          0, 1, 1, 32'hA5,         1, 32'hA5, 1, 1));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // random RAM round-trips
        for (int i = 0; i < 8; i++) begin
            idx = 8'($urandom_range(0, 255));
            d   = $urandom;
            apply(mk(0, {22'b0, idx, 2'b00}, d, 1, 0, 0, 32'h0, 0, 32'h0, 0, 0));
            apply(mk(0, {22'b0, idx, 2'b00}, 32'h0, 0, 1, 1, d, 0, 32'h0, 0, 0));
        end

        // cycle counter counts edges since reset release
        apply(mk(1, 32'h0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0));
        for (int n = 0; n < 6; n++) begin
            apply(mk(0, CYCLE_A, 32'h0, 0, 1, 1, 32'(n), 0, 32'h0, 0, 0));
        end

        // counter load and wrap
        apply(mk(0, CYCLE_A, 32'hFFFF_FFFE, 1, 0, 0, 32'h0, 0, 32'h0, 0, 0));
        apply(mk(0, CYCLE_A, 32'h0, 0, 1, 1, 32'hFFFF_FFFE, 0, 32'h0, 0, 0));
        apply(mk(0, CYCLE_A, 32'h0, 0, 1, 1, 32'hFFFF_FFFF, 0, 32'h0, 0, 0));
        apply(mk(0, CYCLE_A, 32'h0, 0, 1, 1, 32'h0000_0000, 0, 32'h0, 0, 0));

        // reset in the middle of MMIO and RAM writes
        apply(mk(0, 32'h20, 32'h0BAD_CAFE, 1, 0, 0, 32'h0, 0, 32'h0, 0, 0));
        apply(mk(0, GPIO_A, 32'h33, 1, 0, 0, 32'h0, 0, 32'h0, 0, 0));
        apply(mk(0, 32'h4000_0000, 32'h0, 0, 1, 1, 32'h0, 0, 32'h0, 0, 0));
        apply(mk(0, SCRATCH_A, 32'h7777_0000, 1, 0, 0, 32'h0, 1, 32'h33, 1, 1));
        apply(mk(1, GPIO_A, 32'hFF, 1, 0, 0, 32'h0, 1, 32'h33, 1, 1));
        apply(mk(0, CYCLE_A, 32'h0, 0, 1, 1, 32'h0, 1, 32'h0, 1, 0));
        apply(mk(1, 32'h20, 32'hFFFF_FFFF, 1, 0, 0, 32'h0, 0, 32'h0, 0, 0));
        apply(mk(0, 32'h20, 32'h0, 0, 1, 1, 32'h0BAD_CAFE, 1, 32'h0, 1, 0));
        apply(mk(0, SCRATCH_A, 32'h0, 0, 1, 1, 32'h0, 0, 32'h0, 1, 0));

        if (exp_q.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL scoreboard: %0d leftover entries, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Responder (target) end of the single-cycle core's data-memory port. Accepts `address`/`write_data`/`MemWrite`/`MemRead` from the core and returns `read_data` in the same cycle. Decodes the address into a word-addressed RAM and a small MMIO window (GPIO register, cycle counter, status). Sits between the core top and the board pins, alongside the instruction ROM.

## Interface
- `size`, 32, data/address width
- `mem_depth`, 256, RAM depth in 32-bit words (power of two)
- `MMIO_BASE`, 32'h8000_0000, base address of the MMIO window

- `CLK`  in  1  clock; all state updates on the rising edge
- `RSTa`  in  1  reset, synchronous, active-high
- `address`  in  size  byte address from the core (ALU result)
- `write_data`  in  size  store data
- `MemWrite`  in  1  store strobe, one access per cycle
- `MemRead`  in  1  load strobe
- `read_data`  out  size  load data, combinational from `address`/`MemRead`
- `gpio_out`  out  size  GPIO register contents
- `bus_err`  out  1  sticky access-error flag (mirror of STATUS[0])

## Operation
- Address map, word-aligned only:
  - RAM: `0` .. `4*mem_depth-1`; index = `address[log2(mem_depth)+1:2]`.
  - GPIO at `MMIO_BASE+0x0`: RW.
  - CYCLE at `+0x4`: RW; a write loads the counter.
  - STATUS at `+0x8`: bit0 = err. Writing 1 to bit0 clears it (W1C). Other bits read 0.
  - SCRATCH at `+0xC`: RW, no side effects.
- Error access: `address[1:0]!=0`, or an unmapped address, with `MemRead|MemWrite` asserted.
  - Writes are dropped.
  - Reads return 0.
  - err is set at the next edge.
- `MemRead=0`: `read_data=0`.
- `MemRead&MemWrite` both high: treated as a write. `read_data` still reflects the pre-write contents. err is set.
- CYCLE increments by 1 every cycle and wraps `0xFFFF_FFFF→0`. A write overrides the increment for that edge, so the next cycle reads `write_data`.
- STATUS error and clear at the same edge: set wins, err stays 1.
- RAM array is not cleared by reset. Reset affects only MMIO state.

## Timing
- Reads: zero latency, purely combinational; no `MemRead` pipelining.
- Writes: take effect at the rising edge where `MemWrite=1`. A read of the same location in the same cycle returns the old value; the next cycle returns the new value.
- Reset values, from the first edge with `RSTa=1`:
  - `gpio_out=0`, CYCLE=0, SCRATCH=0, err=0, `bus_err=0`.
  - `read_data` follows decode; RAM reads return prior contents.
- Reset mid-write: reset wins for MMIO registers. A RAM write in the reset cycle is suppressed.
- No back-pressure or wait states: every request completes in one cycle.

## Structure
- Package `mem_map_pkg`:
  - `MMIO_BASE` default and offsets `GPIO_OFS=0x0`, `CYCLE_OFS=0x4`, `STATUS_OFS=0x8`, `SCRATCH_OFS=0xC`.
  - Enum `region_t` {`REG_RAM`, `REG_MMIO`, `REG_NONE`}.
  - STATUS bit index constant.
- Sub-module `data_ram`: `mem_depth`×`size` array, combinational read port, synchronous write port with write-enable. No reset.
- Top holds the decoder, MMIO registers, read mux and error logic.

## Test plan
- Basic RAM access: write `0xDEADBEEF` to `0x10`, read `0x10` next cycle → `0xDEADBEEF`. A same-cycle read during the write returns the old value.
- GPIO and SCRATCH:
  - After reset, write `0x0000_00A5` to GPIO → `gpio_out=0xA5` one edge later; a GPIO read returns `0xA5`.
  - A SCRATCH round-trip returns the written value.
- Cycle counter:
  - Reset, then read CYCLE on cycle N after reset release → N.
  - Write `0xFFFF_FFFE` → read `0xFFFF_FFFE`, then `0xFFFF_FFFF`, then `0`.
- Error detection:
  - Write to `0x13` (misaligned) → RAM unchanged, `bus_err=1` next cycle.
  - Read of `0x4000_0000` (unmapped) returns 0.
  - W1C to STATUS → `bus_err=0`.
- Simultaneous set and clear: W1C to STATUS in the same cycle as an error access → `bus_err` stays 1.
- Reset mid-operation:
  - Assert `RSTa` with `MemWrite=1` to GPIO with `0xFF` → `gpio_out=0`, CYCLE=0.
  - A RAM write issued in the reset cycle is not stored.
  - RAM contents written before reset remain readable.
